// File: rtl/i2c_target_rx_if.sv
// Bus-side signal bundle for the write-only I2C target: pin levels in, SDA pull-down
// and received-byte stream out.
interface i2c_target_rx_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe,
        input  data_out,
        input  data_valid,
        input  busy
    );

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe,
        output data_out,
        output data_valid,
        output busy
    );
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: oversampled SCL/SDA, START/STOP decode, 7-bit address match,
// byte ACK, and a one-cycle strobe per received data byte.
module i2c_target_rx #(
    parameter logic [6:0]  ADDR        = 7'h2A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    i2c_target_rx_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StIgnore
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d, shift_next;
    logic [2:0] cnt_q, cnt_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;

    // Synchronizers reset high (idle bus level) so reset release creates no false edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shift_q      <= 8'h00;
            cnt_q        <= 3'd0;
            sda_oe_q     <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            sda_oe_q     <= sda_oe_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        sda_oe_d     = sda_oe_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        shift_next   = {shift_q[6:0], sda_s};

        if (!ena) begin
            state_d  = StIdle;
            shift_d  = 8'h00;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            state_d  = StAddr;
            shift_d  = 8'h00;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = StIdle;
            shift_d  = 8'h00;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = (shift_next[7:1] == ADDR && !shift_next[0]) ?
                                      StAddrAck : StIgnore;
                        end
                    end
                end
                // sda_oe doubles as the ACK phase flag: first fall drives, second releases.
                StAddrAck, StDataAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = StData;
                            cnt_d    = 3'd0;
                        end
                    end
                end
                StData: begin
                    if (scl_rise) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            data_out_d   = shift_next;
                            data_valid_d = 1'b1;
                            state_d      = StDataAck;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = (state_q == StAddrAck) || (state_q == StData) ||
                            (state_q == StDataAck);

endmodule
